// File: rtl/circle_pkg.sv
// Shared geometry, state and octant definitions for the midpoint circle drawer.
// The octant mapping lives here so every consumer agrees on pixel order.
package circle_pkg;

  localparam logic signed [9:0] SCREEN_W = 10'sd160;
  localparam logic signed [9:0] SCREEN_H = 10'sd120;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PLOT,
    UPDATE,
    DONE
  } circle_state_t;

  typedef logic [2:0] octant_t;

  typedef struct packed {
    logic signed [9:0] x;
    logic signed [9:0] y;
  } pixel_t;

  // Maps one (ox, oy) offset onto the octant selected by oct, relative to the centre.
  function automatic pixel_t octant_pixel(
    input logic [7:0]        cx,
    input logic [6:0]        cy,
    input logic signed [9:0] ox,
    input logic signed [9:0] oy,
    input octant_t           oct
  );
    logic signed [9:0] sx;
    logic signed [9:0] sy;
    pixel_t            p;
    sx = signed'({2'b00, cx});
    sy = signed'({3'b000, cy});
    case (oct)
      3'd0:    begin p.x = sx + ox; p.y = sy + oy; end
      3'd1:    begin p.x = sx + oy; p.y = sy + ox; end
      3'd2:    begin p.x = sx - ox; p.y = sy + oy; end
      3'd3:    begin p.x = sx - oy; p.y = sy + ox; end
      3'd4:    begin p.x = sx - ox; p.y = sy - oy; end
      3'd5:    begin p.x = sx - oy; p.y = sy - ox; end
      3'd6:    begin p.x = sx + ox; p.y = sy - oy; end
      default: begin p.x = sx + oy; p.y = sy - ox; end
    endcase
    return p;
  endfunction

  function automatic logic on_screen(input pixel_t p);
    return (p.x >= 10'sd0) && (p.x < SCREEN_W) && (p.y >= 10'sd0) && (p.y < SCREEN_H);
  endfunction

endpackage

// File: rtl/circle.sv
// Midpoint circle outline drawer: one candidate pixel per PLOT cycle to the VGA
// adapter plot port, off-screen pixels suppressed, start/done handshake.
module circle
  import circle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  input  logic [2:0] colour,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  circle_state_t     state_q, state_d;
  logic [7:0]        cx_q, cx_d;
  logic [6:0]        cy_q, cy_d;
  logic [7:0]        r_q, r_d;
  logic [2:0]        colour_q, colour_d;
  logic signed [9:0] ox_q, ox_d;
  logic signed [9:0] oy_q, oy_d;
  logic signed [11:0] crit_q, crit_d;
  octant_t           oct_q, oct_d;

  logic signed [9:0] oy_inc;
  logic signed [9:0] ox_dec;
  logic signed [9:0] ox_next;
  logic signed [9:0] diff;
  pixel_t            pix;
  logic              pix_on;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    r_d      = r_q;
    colour_d = colour_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    crit_d   = crit_q;
    oct_d    = oct_q;
    oy_inc   = oy_q + 10'sd1;
    ox_dec   = ox_q - 10'sd1;
    ox_next  = ox_q;
    diff     = oy_inc - ox_dec;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cx_d     = centre_x;
          cy_d     = centre_y;
          r_d      = radius;
          colour_d = colour;
          state_d  = INIT;
        end
      end
      INIT: begin
        ox_d    = signed'({2'b00, r_q});
        oy_d    = 10'sd0;
        crit_d  = 12'sd1 - signed'({4'b0000, r_q});
        oct_d   = 3'd0;
        state_d = PLOT;
      end
      PLOT: begin
        oct_d = oct_q + 3'd1;
        if (oct_q == 3'd7) state_d = UPDATE;
      end
      UPDATE: begin
        oy_d = oy_inc;
        // {v, 1'b1} sign-extended by one bit is exactly 2*v + 1.
        if (crit_q <= 12'sd0) begin
          crit_d = crit_q + signed'({oy_inc[9], oy_inc, 1'b1});
        end else begin
          ox_next = ox_dec;
          ox_d    = ox_dec;
          crit_d  = crit_q + signed'({diff[9], diff, 1'b1});
        end
        oct_d = 3'd0;
        if (oy_inc <= ox_next) state_d = PLOT;
        else                   state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix    = octant_pixel(cx_q, cy_q, ox_q, oy_q, oct_q);
  assign pix_on = on_screen(pix);

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    done       = (state_q == DONE);
    if (state_q == PLOT) begin
      vga_x      = pix.x[7:0];
      vga_y      = pix.y[6:0];
      vga_colour = colour_q;
      vga_plot   = pix_on;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      r_q      <= '0;
      colour_q <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
      oct_q    <= '0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      r_q      <= r_d;
      colour_q <= colour_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      crit_q   <= crit_d;
      oct_q    <= oct_d;
    end
  end

endmodule

// File: tb/tb_circle.sv
// Self-checking bench for circle: compares every cycle's VGA/done outputs
// against an expected trace built from an integer midpoint-circle model.
module tb_circle;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic [2:0] colour;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int total = 0;
  int bad   = 0;

  // Packed per-cycle observation: {done, plot, colour, x, y}.
  logic [19:0] exp_q[$];

  const int SX[8] = '{1, 1, -1, -1, -1, -1, 1, 1};
  const int SY[8] = '{1, 1, 1, 1, -1, -1, -1, -1};

  circle dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .centre_x  (centre_x),
    .centre_y  (centre_y),
    .radius    (radius),
    .colour    (colour),
    .done      (done),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] observed();
    return {done, vga_plot, vga_colour, vga_x, vga_y};
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [19:0] pix_entry(input int x, input int y, input logic [2:0] col);
    logic on;
    logic [7:0] xb;
    logic [6:0] yb;
    on = (x >= 0) && (x < 160) && (y >= 0) && (y < 120);
    xb = 8'(x);
    yb = 7'(y);
    return {1'b0, on, col, xb, yb};
  endfunction

  // Expected trace from INIT through the first DONE cycle.
  task automatic build_trace(input int cx, input int cy, input int r, input logic [2:0] col);
    int ox, oy, crit, a, b;
    exp_q.delete();
    exp_q.push_back('0);
    ox = r; oy = 0; crit = 1 - r;
    do begin
      for (int k = 0; k < 8; k++) begin
        a = (k % 2 == 1) ? oy : ox;
        b = (k % 2 == 1) ? ox : oy;
        exp_q.push_back(pix_entry(cx + SX[k] * a, cy + SY[k] * b, col));
      end
      exp_q.push_back('0);
      oy = oy + 1;
      if (crit <= 0) crit = crit + 2 * oy + 1;
      else begin
        ox   = ox - 1;
        crit = crit + 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
    exp_q.push_back({1'b1, 19'b0});
  endtask

  // Hand-written radius-1 trace at (80,60).
  task automatic build_r1(input logic [2:0] col);
    int xs[16] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
    int ys[16] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};
    exp_q.delete();
    exp_q.push_back('0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(pix_entry(xs[i], ys[i], col));
      if (i == 7 || i == 15) exp_q.push_back('0);
    end
    exp_q.push_back({1'b1, 19'b0});
  endtask

  // Raise start and walk the expected trace; inputs are scrambled after INIT
  // to show they were latched.
  task automatic run(input string tag, input bit drop_early, input int stop_at);
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      if (i == stop_at) break;
      check(tag, observed(), exp_q[i]);
      if (i == 0) begin
        centre_x = 8'($urandom);
        centre_y = 7'($urandom);
        radius   = 8'($urandom);
        colour   = 3'($urandom);
        if (drop_early) start = 1'b0;
      end
    end
  endtask

  task automatic draw(input string tag, input int cx, input int cy, input int r,
                      input logic [2:0] col, input bit drop_early);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius   = 8'(r);
    colour   = col;
    build_trace(cx, cy, r, col);
    run(tag, drop_early, -1);
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    step();
    check(tag, observed(), '0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    centre_x = '0; centre_y = '0; radius = '0; colour = '0;
    step(); step();
    check("reset_outputs", observed(), '0);
    rst = 1'b0;
    step();
    check("idle_quiet", observed(), '0);

    draw("r0", 80, 60, 0, 3'b010, 1'b0);
    release_start("r0_release");

    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd1; colour = 3'b101;
    build_r1(3'b101);
    run("r1", 1'b0, -1);
    release_start("r1_release");

    draw("clip_origin", 0, 0, 10, 3'b111, 1'b0);
    release_start("clip_release");

    draw("r30", 80, 60, 30, 3'b001, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step();
      check("done_hold", observed(), {1'b1, 19'b0});
    end
    release_start("handshake_drop");
    draw("redraw", 80, 60, 30, 3'b110, 1'b0);
    release_start("redraw_release");

    draw("early_drop", 150, 5, 12, 3'b011, 1'b1);
    step();
    check("early_drop_idle", observed(), '0);

    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd20; colour = 3'b100;
    build_trace(80, 60, 20, 3'b100);
    run("mid_reset_pre", 1'b0, 22);
    rst = 1'b1;
    step();
    check("mid_reset_outputs", observed(), '0);
    rst = 1'b0;
    draw("after_reset", 70, 50, 20, 3'b010, 1'b0);
    release_start("after_reset_release");

    for (int n = 0; n < 6; n++) begin
      draw("random", int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
           int'($urandom_range(0, 255)), 3'($urandom), 1'b0);
      release_start("random_release");
    end

    draw("edge_corner", 159, 119, 255, 3'b111, 1'b0);
    release_start("edge_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/circle.md
# circle

Draws a Bresenham (midpoint) circle outline of a given centre, radius and colour on the 160×120 VGA framebuffer. It sits beside the screen-fill stage, directly upstream of the VGA adapter, and emits one pixel write per cycle on the adapter's plot port. Pixels falling outside the screen are suppressed. Drawing is started and acknowledged with the lab's standard start/done handshake.

## Interface
Parameters:
- none; screen geometry comes from `circle_pkg`.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain)
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a draw; held high until `done` is seen
- `centre_x`  in  8  centre column, 0–159
- `centre_y`  in  7  centre row, 0–119
- `radius`  in  8  radius in pixels, 0–255
- `colour`  in  3  pixel colour
- `done`  out  1  draw complete; held until `start` falls
- `vga_x`  out  8  pixel column to the VGA adapter
- `vga_y`  out  7  pixel row to the VGA adapter
- `vga_colour`  out  3  pixel colour to the VGA adapter
- `vga_plot`  out  1  write strobe to the VGA adapter

## Operation
- States: IDLE, INIT, PLOT, UPDATE, DONE.
- **IDLE**
  - `start`=1 → INIT.
  - `centre_x`, `centre_y`, `radius` and `colour` are latched on this edge; later input changes are ignored until the next draw.
- **INIT** (1 cycle)
  - `oy`=0, `ox`=`radius`, `crit`=1−`radius`, `oct`=0.
  - Next state is PLOT.
- **PLOT** (8 cycles, `oct`=0..7). Each cycle drives one pixel:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx−ox, cy+oy)
  - 3: (cx−oy, cy+ox)
  - 4: (cx−ox, cy−oy)
  - 5: (cx−oy, cy−ox)
  - 6: (cx+ox, cy−oy)
  - 7: (cx+oy, cy−ox)
  - After `oct`=7 → UPDATE.
- **UPDATE** (1 cycle)
  - `oy`←`oy`+1.
  - If `crit`≤0: `crit`←`crit`+2·(`oy`+1)+1.
  - Else: `ox`←`ox`−1 and `crit`←`crit`+2·(`oy`+1−(`ox`−1))+1.
  - All expressions use the incremented/decremented values.
  - If new `oy`≤new `ox` → PLOT with `oct`=0; else → DONE.
- **DONE**
  - `done`=1.
  - `start`=0 → IDLE. While `start` stays high, remain in DONE; no redraw occurs.
- **Arithmetic**
  - Coordinates are computed signed 10-bit; `crit` is signed 12-bit; no overflow is possible for the input ranges.
  - A pixel is on-screen iff 0≤x≤159 and 0≤y≤119.
  - Off-screen pixels still consume their PLOT cycle, with `vga_plot`=0.
- **Duplicates**: pixels that coincide (axes, diagonals, radius 0) are written repeatedly; this is legal.

## Timing
- **VGA outputs** are a Moore decode of state/offset registers and are valid in the same cycle as the PLOT state.
  - During PLOT: `vga_x`/`vga_y` take the low bits of the computed coordinate, `vga_colour`=latched colour, `vga_plot`=on-screen flag.
  - Outside PLOT: `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0.
- **Latency**
  - First pixel appears 2 cycles after the edge on which `start` is sampled (IDLE→INIT→PLOT).
  - Total time from INIT to DONE entry is 1+9·N cycles, where N is the number of PLOT/UPDATE iterations.
- **Reset**
  - `rst`=1 at any edge, including mid-draw → IDLE on that edge.
  - All outputs are 0 and `done`=0 in the following cycle.
  - No partial state survives.
  - If `start` is still high after `rst` drops, a new draw begins from IDLE, with inputs re-latched.
- **Input changes**: `start` falling during INIT/PLOT/UPDATE does not abort the draw. `done` is asserted on completion; if `start` is already low, the FSM returns to IDLE the cycle after DONE.

## Structure
- `circle_pkg` contains:
  - `SCREEN_W`=160, `SCREEN_H`=120
  - the state enum `circle_state_t`
  - 3-bit octant type `octant_t`
  - function `octant_pixel(cx, cy, ox, oy, oct)` returning the signed coordinate pair.
- No sub-module; the datapath and FSM live in one module. The octant mapping is the package function so the bench's reference model can reuse it.

## Test plan
- **Radius 0, centre (80,60), colour 3'b010:**
  - Required: 8 plots, all (80,60) with colour 3'b010.
  - Required: `done` rises exactly 10 cycles after INIT (1+9).
- **Radius 1, centre (80,60):**
  - First pass must plot, in order: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
  - Second pass must plot, in order: (81,61),(81,61),(79,61),(79,61),(79,59),(79,59),(81,59),(81,59).
  - Required: DONE entered after 19 cycles from INIT.
- **Clipping, centre (0,0), radius 10:**
  - Required: no `vga_plot`=1 with an off-screen coordinate.
  - Required: quadrant x≥0,y≥0 pixels match the reference model exactly; every other octant cycle has `vga_plot`=0.
- **Radius 30, centre (80,60):** plotted pixel set must equal the package-function model's set, and `done` must hold high while `start` is held.
- **Handshake:** raise `start`, wait for `done`, hold `start` 50 more cycles.
  - Required: no further plots during those 50 cycles.
  - Drop `start` → required: `done`=0 next cycle.
  - Raise `start` again → required: a fresh draw.
- **Reset mid-draw:** assert `rst` during the 3rd PLOT pass of radius 20.
  - Required: next cycle has `vga_plot`=0, `done`=0, state IDLE.
  - Release `rst` with `start` high → required: a complete redraw from INIT.
